// File: rtl/pbkdf2_xor_accumulator.sv
// pbkdf2_xor_accumulator
//   Folds a slot-ordered stream of per-iteration HMAC outputs into per-slot
//   running XORs. Each result is emitted once per slot per block, on the
//   word that closes its final iteration. A result that arrives while the
//   output register is still held by the consumer is dropped and counted.
//
// Ports
//   clk          : single clock, all logic on posedge
//   device_reset : synchronous active-high reset
//   start        : one-cycle pulse, begins a run (honoured only when idle)
//   iter_count   : iterations minus one, sampled on an accepted start
//   hash_valid   : hash_in carries the next slot-ordered word
//   hash_in      : HMAC output for the current slot/iteration/block
//   out_valid    : result held on out_hash/out_slot/out_block
//   out_ready    : consumer accepts when out_valid && out_ready
//   out_hash     : accumulated XOR result
//   out_slot     : slot index of the result
//   out_block    : block index of the result
//   busy         : high while a run is in progress
//   done         : one-cycle pulse after the last word of the last block
//   overflow     : sticky, a result was dropped
//   drop_count   : saturating count of dropped results
module pbkdf2_xor_accumulator #(
  parameter int WIDTH  = 160,
  parameter int DEPTH  = 167,
  parameter int ITER_W = 12,
  parameter int BLOCKS = 2,
  parameter int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int BLK_W  = (BLOCKS > 1) ? $clog2(BLOCKS) : 1
) (
  input  logic              clk,
  input  logic              device_reset,
  input  logic              start,
  input  logic [ITER_W-1:0] iter_count,
  input  logic              hash_valid,
  input  logic [WIDTH-1:0]  hash_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_hash,
  output logic [SLOT_W-1:0] out_slot,
  output logic [BLK_W-1:0]  out_block,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [7:0]        drop_count
);

  localparam logic [0:0]        ST_IDLE   = 1'b0;
  localparam logic [0:0]        ST_RUN    = 1'b1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DEPTH - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLOCKS - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [BLK_W-1:0]  BLK_ONE   = BLK_W'(1);
  localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);

  logic [0:0]        r_state;
  logic [SLOT_W-1:0] r_slot;
  logic [ITER_W-1:0] r_iter;
  logic [ITER_W-1:0] r_iter_last;
  logic [BLK_W-1:0]  r_blk;
  logic [WIDTH-1:0]  r_acc [DEPTH];

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_hash;
  logic [SLOT_W-1:0] r_out_slot;
  logic [BLK_W-1:0]  r_out_block;
  logic              r_done;
  logic              r_overflow;
  logic [7:0]        r_drop_count;

  logic              w_consume;
  logic              w_slot_wrap;
  logic              w_iter_fin;
  logic              w_blk_fin;
  logic              w_last_word;
  logic              w_final;
  logic              w_load;
  logic              w_drop;
  logic [WIDTH-1:0]  w_acc_next;

  // Decode the position of the current word and form its accumulated value.
  always_comb begin
    w_consume   = (r_state == ST_RUN) && hash_valid;
    w_slot_wrap = (r_slot == SLOT_LAST);
    w_iter_fin  = (r_iter == r_iter_last);
    w_blk_fin   = (r_blk == BLK_LAST);
    w_last_word = w_consume && w_slot_wrap && w_iter_fin && w_blk_fin;
    w_final     = w_consume && w_iter_fin;
    w_load      = w_final && (!r_out_valid || out_ready);
    w_drop      = w_final && r_out_valid && !out_ready;
    // Iteration 0 overwrites, so stale contents from earlier runs never leak;
    // this also yields hash_in alone when only one iteration is programmed.
    if (r_iter == {ITER_W{1'b0}}) begin
      w_acc_next = hash_in;
    end else begin
      w_acc_next = r_acc[r_slot] ^ hash_in;
    end
  end

  // Run control FSM with slot/iteration/block counters.
  always_ff @(posedge clk) begin
    if (device_reset) begin
      r_state     <= ST_IDLE;
      r_slot      <= {SLOT_W{1'b0}};
      r_iter      <= {ITER_W{1'b0}};
      r_iter_last <= {ITER_W{1'b0}};
      r_blk       <= {BLK_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_RUN;
            r_iter_last <= iter_count;
            r_slot      <= {SLOT_W{1'b0}};
            r_iter      <= {ITER_W{1'b0}};
            r_blk       <= {BLK_W{1'b0}};
          end
        end
        ST_RUN: begin
          if (w_consume) begin
            if (w_last_word) begin
              r_state <= ST_IDLE;
            end
            if (w_slot_wrap) begin
              r_slot <= {SLOT_W{1'b0}};
              if (w_iter_fin) begin
                r_iter <= {ITER_W{1'b0}};
                r_blk  <= w_blk_fin ? {BLK_W{1'b0}} : (r_blk + BLK_ONE);
              end else begin
                r_iter <= r_iter + ITER_ONE;
              end
            end else begin
              r_slot <= r_slot + SLOT_ONE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-slot accumulator; a register array so a slot revisited on the very
  // next cycle (DEPTH==1) reads the value written on the previous edge.
  always_ff @(posedge clk) begin
    if (!device_reset && w_consume) begin
      r_acc[r_slot] <= w_acc_next;
    end
  end

  // Output register, drop accounting and the done pulse.
  always_ff @(posedge clk) begin
    if (device_reset) begin
      r_out_valid  <= 1'b0;
      r_out_hash   <= {WIDTH{1'b0}};
      r_out_slot   <= {SLOT_W{1'b0}};
      r_out_block  <= {BLK_W{1'b0}};
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= 8'h00;
    end else begin
      r_done <= w_last_word;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_hash  <= w_acc_next;
        r_out_slot  <= r_slot;
        r_out_block <= r_blk;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'h01;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_hash   = r_out_hash;
  assign out_slot   = r_out_slot;
  assign out_block  = r_out_block;
  assign busy       = (r_state == ST_RUN);
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule
